aes_stream_io: RTL and testbench
================================

// Module: aes_stream_io
// PURPOSE
//  Byte-serial front/back end for the AES cipher and decipher cores.
//  - Assembles 16 incoming bytes into a 128-bit block and pulses the core start.
//  - Captures the 128-bit core result on core_done and streams it out as 16 bytes.
//  - Both byte ports use a valid/ready handshake. The block sits between an
//    external byte link (switch/UART bridge) and one AES_Cipher/AES_DeCipher.
// PARAMETERS
//  TIMEOUT   64  cycles to wait in WAIT for core_done before flagging an error (>=2)
//  CNT_W      7  width of timeout counter; must hold TIMEOUT
// PORTS
//  clk          in   1    system clock, all logic on posedge
//  reset        in   1    synchronous, active-low reset (0 = reset)
//  in_data      in   8    input byte
//  in_valid     in   1    in_data valid
//  in_ready     out  1    block can accept a byte this cycle
//  core_block   out  128  assembled block to core; byte 0 = [127:120]
//  core_start   out  1    one-cycle start pulse to core
//  core_result  in   128  core output; sampled only when core_done=1 in WAIT
//  core_done    in   1    core result valid strobe
//  out_data     out  8    output byte
//  out_valid    out  1    out_data valid
//  out_ready    in   1    consumer accepts out_data this cycle
//  busy         out  1    1 in any state other than FILL
//  timeout_err  out  1    sticky: core_done not seen within TIMEOUT cycles
// BEHAVIOUR
//  Reset (posedge clk with reset=0):
//  - state=FILL; byte and timeout counters=0.
//  - core_block=0, result reg=0, core_start=0, out_valid=0, timeout_err=0.
//  - in_ready = (state==FILL) & reset, so it is 0 while reset is held.
//  - Reset mid-operation discards the partial block or result; no start pulse.
//  FSM: FILL -> START -> WAIT -> DRAIN -> FILL
//  - FILL:
//    - in_ready=1. A byte is accepted when in_valid & in_ready.
//    - Byte k (k=0..15) is written to core_block[127-8k -: 8]; k increments.
//    - Accepting byte 15 moves to START and clears k.
//    - Gaps in in_valid are allowed.
//  - START:
//    - core_start=1 for exactly this cycle; in_ready=0; go to WAIT.
//    - Latency: byte 15 accepted at edge N -> core_start high during cycle N+1.
//  - WAIT:
//    - core_block is held stable; the timeout counter increments each cycle.
//    - core_done=1: latch core_result, clear the counter, go to DRAIN.
//      out_valid rises on the following cycle.
//    - counter==TIMEOUT-1 with no core_done: set timeout_err, drop the block,
//      go to FILL.
//    - core_done in the same cycle as the timeout wins; no error.
//  - DRAIN:
//    - out_valid=1; out_data = result[127-8j -: 8].
//    - j increments on each out_valid & out_ready.
//    - out_data is held stable while out_ready=0.
//    - Accepting byte 15 moves to FILL, clears j, and drops out_valid next cycle.
//  - core_done outside WAIT is ignored.
//  - in_valid outside FILL is not accepted; the byte is held off by in_ready=0.
//  - timeout_err clears only on reset.
//  - Counters wrap never; byte counters are 4 bits and are bounded by the FSM.
//  - Throughput: one block per 16+1+core+16 cycles at most; no overlap of fill and drain.
// TESTING
//  1. After reset, feed 00 11 22 .. ff back-to-back.
//     -> core_block=00112233445566778899aabbccddeeff and one core_start pulse.
//     Model core_done 10 cycles later with 69c4e0d86a7b0430d8cdb78070b4c55a,
//     out_ready=1 -> out bytes 69,c4,e0,..,c5,5a with out_valid for exactly 16 cycles.
//  2. Backpressure: toggle out_ready 1/0 each cycle.
//     -> out_data never changes while out_ready=0; all 16 bytes appear in order
//     with no duplicates.
//  3. Input gaps: in_valid random 50%.
//     -> identical core_block to test 1; core_start only after the 16th accepted byte.
//  4. Timeout: no core_done for 64 cycles.
//     -> timeout_err=1 and return to FILL; a new block of 16 bytes then completes
//     normally, and timeout_err stays 1.
//  5. Reset low after 7 bytes, then release.
//     -> in_ready=0 during reset, no core_start; a fresh 16 bytes yields a correct block.
//  6. core_done pulsed during FILL and DRAIN -> no state change, result unchanged.

Source files
------------

// File: rtl/aes_stream_io.sv
// Byte-serial front/back end for an AES cipher/decipher core: packs 16 input
// bytes into a block, starts the core, then streams the 128-bit result out bytewise.
//
// state | meaning
// FILL  | accepting input bytes into core_block
// START | one-cycle core_start pulse
// WAIT  | waiting for core_done, timeout counter running
// DRAIN | streaming the latched result out
module aes_stream_io #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] core_block,
    output logic         core_start,
    input  logic [127:0] core_result,
    input  logic         core_done,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [3:0]       in_cnt;
    logic [3:0]       out_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [127:0]     result;
    logic [6:0]       in_lsb;
    logic [6:0]       out_lsb;

    // Byte k sits at bit (15-k)*8; for a 4-bit k that is simply ~k.
    assign in_lsb   = {~in_cnt, 3'b000};
    assign out_lsb  = {~out_cnt, 3'b000};
    assign in_ready = (state == FILL) && reset;
    assign busy     = (state != FILL);
    assign out_data = result[out_lsb +: 8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FILL;
            in_cnt      <= 4'd0;
            out_cnt     <= 4'd0;
            tmo_cnt     <= '0;
            core_block  <= '0;
            result      <= '0;
            core_start  <= 1'b0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid) begin
                        core_block[in_lsb +: 8] <= in_data;
                        if (in_cnt == 4'd15) begin
                            in_cnt     <= 4'd0;
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            in_cnt <= in_cnt + 4'd1;
                        end
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the terminal cycle still counts as in time.
                    if (core_done) begin
                        result    <= core_result;
                        tmo_cnt   <= '0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_cnt == 4'd15) begin
                            out_cnt   <= 4'd0;
                            out_valid <= 1'b0;
                            state     <= FILL;
                        end else begin
                            out_cnt <= out_cnt + 4'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_io.sv
// Bench for aes_stream_io: vector table driven through fill/start/wait/drain,
// output bytes checked against a scoreboard queue, plus timeout and reset sequences.
module tb_aes_stream_io;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] core_block;
    logic         core_start;
    logic [127:0] core_result;
    logic         core_done;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         timeout_err;

    aes_stream_io #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_block(core_block), .core_start(core_start),
        .core_result(core_result), .core_done(core_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [127:0] blk;
        logic [127:0] res;
        int           gap;
        int           rmode;
        int           delay;
        bit           glitch;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] sb[$];
    int         tests = 0;
    int         fails = 0;
    int         start_cnt = 0;
    int         acc_cnt = 0;
    int         obs_cnt = 0;
    int         valid_cycles = 0;
    int         ready_mode = 0;
    bit         hold_pending = 0;
    logic [7:0] held = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observes handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            acc_cnt = 0;
            hold_pending = 0;
        end else begin
            if (in_valid && in_ready) acc_cnt++;
            if (core_start === 1'b1) begin
                start_cnt++;
                checki("start_after_16_bytes", acc_cnt, 16);
                acc_cnt = 0;
            end
            if (out_valid === 1'b1) valid_cycles++;
            if (hold_pending && out_valid === 1'b1)
                check("out_hold_stable", 128'(out_data), 128'(held));
            if (out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    checki("unexpected_out_byte", 1, 0);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    check("out_byte", 128'(out_data), 128'(exp_b));
                end
                obs_cnt++;
            end
            hold_pending = (out_valid === 1'b1) && !out_ready;
            held = out_data;
        end
    end

    task automatic feed(input logic [127:0] blk, input int n, input int gap);
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < 20 && $urandom_range(0, 99) < gap; g++) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = blk[127 - 8*b -: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input logic exp_err);
        int  start0, obs0, vc0;
        bit  drained;
        start0 = start_cnt;
        ready_mode = v.rmode;
        if (v.glitch) begin
            core_result = ~v.res;
            core_done   = 1'b1;
            tick();
            core_done = 1'b0;
            checki("done_in_fill_ignored", int'(busy), 0);
        end
        feed(v.blk, 16, v.gap);
        checki("start_latency", int'(core_start), 1);
        check("core_block", core_block, v.blk);
        checki("in_ready_in_start", int'(in_ready), 0);
        checki("busy_in_start", int'(busy), 1);
        tick();
        checki("start_one_cycle", int'(core_start), 0);
        in_valid = 1'b1;
        in_data  = 8'hee;
        repeat (v.delay - 1) tick();
        in_valid = 1'b0;
        check("core_block_held", core_block, v.blk);
        for (int b = 0; b < 16; b++) sb.push_back(v.res[127 - 8*b -: 8]);
        obs0 = obs_cnt;
        vc0  = valid_cycles;
        core_result = v.res;
        core_done   = 1'b1;
        tick();
        core_done = 1'b0;
        core_result = {4{$urandom}};
        checki("out_valid_rise", int'(out_valid), 1);
        drained = 0;
        for (int i = 0; i < 400; i++) begin
            if (!out_valid && sb.size() == 0) begin
                drained = 1;
                break;
            end
            core_done   = v.glitch && (obs_cnt - obs0 == 5);
            core_result = ~v.res;
            tick();
        end
        core_done = 1'b0;
        checki("drain_complete", int'(drained), 1);
        checki("out_byte_count", obs_cnt - obs0, 16);
        if (v.rmode == 0) checki("out_valid_cycles", valid_cycles - vc0, 16);
        checki("start_pulses", start_cnt - start0, 1);
        checki("no_accept_while_busy", acc_cnt, 0);
        checki("idle_after_drain", int'(busy), 0);
        checki("timeout_err", int'(timeout_err), int'(exp_err));
        sb.delete();
    endtask

    initial begin
        int lat;
        int start0;
        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, 10, 1'b0};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1, 3, 1'b0};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, 128'h3925841d02dc09fbdc118597196a0b32, 50, 0, 1, 1'b0};
        vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 30, 2, 64, 1'b0};
        vecs[4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 0, 2, 20, 1'b1};

        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        core_done = 1'b0;
        core_result = '0;
        out_ready = 1'b1;
        tick();
        tick();
        checki("rst_in_ready", int'(in_ready), 0);
        checki("rst_busy", int'(busy), 0);
        checki("rst_core_start", int'(core_start), 0);
        checki("rst_out_valid", int'(out_valid), 0);
        checki("rst_timeout_err", int'(timeout_err), 0);
        check("rst_core_block", core_block, 128'h0);
        check("rst_out_data", 128'(out_data), 128'h0);
        reset = 1'b1;
        tick();
        checki("in_ready_after_rst", int'(in_ready), 1);

        for (int i = 0; i < 5; i++) apply_vec(vecs[i], 1'b0);

        // Timeout: no core_done at all.
        start0 = start_cnt;
        feed(128'hffeeddccbbaa99887766554433221100, 16, 0);
        checki("tmo_start", int'(core_start), 1);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (!busy) break;
        end
        checki("timeout_latency", lat, 65);
        checki("timeout_err_set", int'(timeout_err), 1);
        checki("timeout_no_out", int'(out_valid), 0);
        checki("timeout_start_pulses", start_cnt - start0, 1);
        apply_vec(vecs[0], 1'b1);

        // Reset after 7 bytes discards the partial block.
        start0 = start_cnt;
        feed(128'hdeadbeef0123456789abcdef55aa55aa, 7, 0);
        reset = 1'b0;
        tick();
        checki("midrst_in_ready", int'(in_ready), 0);
        check("midrst_core_block", core_block, 128'h0);
        checki("midrst_timeout_err", int'(timeout_err), 0);
        tick();
        checki("midrst_in_ready_held", int'(in_ready), 0);
        tick();
        reset = 1'b1;
        tick();
        checki("midrst_no_start", start_cnt - start0, 0);
        checki("midrst_busy", int'(busy), 0);
        apply_vec(vecs[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
